// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Qualifies an asynchronous PLL lock indication and sequences the core and
//   pixel resets. The lock input is synchronized. It must then stay high for
//   STABLE_CYCLES consecutive cycles before the core reset is released. The
//   pixel reset is released PIXEL_DELAY cycles after the core reset. If lock is
//   lost after the core reset has been released, both resets are reasserted and
//   a sticky lock_lost flag is set.
//
// Parameters
//   SYNC_STAGES   : synchronizer depth on pll_locked (2..4)
//   STABLE_CYCLES : consecutive locked cycles needed before core release (2..65535)
//   PIXEL_DELAY   : cycles from core release to pixel release (1..255)
//
// Ports
//   clk_core    in   core clock, the only clock of the block
//   rst_n       in   synchronous active-low reset
//   pll_locked  in   raw PLL lock, asynchronous to clk_core
//   status_clr  in   single-cycle pulse that clears lock_lost
//   core_rst_n  out  active-low reset for core/SRAM logic
//   pixel_rst_n out  active-low reset for pixel/TMDS logic
//   sys_ready   out  high only while running
//   lock_lost   out  sticky flag, set on loss of lock after core release
//   loss_count  out  saturating count of lock-loss events
//
// Build option
//   RESET_SEQ_LOSS_CNT_EN : when defined, loss_count is a saturating 8-bit
//                           counter; otherwise loss_count is tied to zero.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned PIXEL_DELAY   = 16
) (
  input  logic       clk_core,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       status_clr,
  output logic       core_rst_n,
  output logic       pixel_rst_n,
  output logic       sys_ready,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned DLY_W  = (PIXEL_DELAY > 1) ? $clog2(PIXEL_DELAY) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(PIXEL_DELAY - 1);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_CORE_UP   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;

  logic [1:0]        state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;

  logic core_rst_n_q, core_rst_n_d;
  logic pixel_rst_n_q, pixel_rst_n_d;
  logic sys_ready_q, sys_ready_d;
  logic lock_lost_q, lock_lost_d;
  logic loss_evt;

  // Lock synchronizer: only the last stage is used downstream.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next state, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    loss_evt   = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = ST_STABLE;
          stab_cnt_d = '0;
        end
      end
      ST_STABLE: begin
        // A drop here is still qualification: restart silently, no loss event.
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d   = ST_CORE_UP;
          dly_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      ST_CORE_UP: begin
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          dly_cnt_d = '0;
          loss_evt  = 1'b1;
        end else if (dly_cnt_q == DLY_LAST) begin
          state_d = ST_RUN;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_WAIT_LOCK;
          dly_cnt_d = '0;
          loss_evt  = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase

    // Outputs are decoded from the next state so that they change on the
    // same edge as the state transition.
    core_rst_n_d  = (state_d == ST_CORE_UP) || (state_d == ST_RUN);
    pixel_rst_n_d = (state_d == ST_RUN);
    sys_ready_d   = (state_d == ST_RUN);

    // A loss event wins over a coincident clear.
    lock_lost_d = lock_lost_q;
    if (loss_evt) begin
      lock_lost_d = 1'b1;
    end else if (status_clr) begin
      lock_lost_d = 1'b0;
    end
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      sync_q        <= '0;
      state_q       <= ST_WAIT_LOCK;
      stab_cnt_q    <= '0;
      dly_cnt_q     <= '0;
      core_rst_n_q  <= 1'b0;
      pixel_rst_n_q <= 1'b0;
      sys_ready_q   <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      dly_cnt_q     <= dly_cnt_d;
      core_rst_n_q  <= core_rst_n_d;
      pixel_rst_n_q <= pixel_rst_n_d;
      sys_ready_q   <= sys_ready_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign pixel_rst_n = pixel_rst_n_q;
  assign sys_ready   = sys_ready_q;
  assign lock_lost   = lock_lost_q;

`ifdef RESET_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating loss counter; status_clr intentionally does not touch it.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_count = loss_cnt_q;
`else
  assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Two instances: A uses the default parameters, B uses small parameters so
//   that hundreds of loss events fit in a short run. A run-length model
//   predicts every output on every cycle. Directed literal checks pin the
//   model's key timing points.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int A_SYNC = 2;
  localparam int A_STAB = 1024;
  localparam int A_PIX  = 16;
  localparam int B_SYNC = 3;
  localparam int B_STAB = 2;
  localparam int B_PIX  = 1;

`ifdef RESET_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_core = 1'b0;
  logic       rst_n;
  logic       pll_a;
  logic       pll_b;
  logic       status_clr;
  logic       core_a, pix_a, rdy_a, lost_a;
  logic       core_b, pix_b, rdy_b, lost_b;
  logic [7:0] cnt_a, cnt_b;

  reset_sequencer #(
    .SYNC_STAGES  (A_SYNC),
    .STABLE_CYCLES(A_STAB),
    .PIXEL_DELAY  (A_PIX)
  ) u_dut_a (
    .clk_core   (clk_core),
    .rst_n      (rst_n),
    .pll_locked (pll_a),
    .status_clr (status_clr),
    .core_rst_n (core_a),
    .pixel_rst_n(pix_a),
    .sys_ready  (rdy_a),
    .lock_lost  (lost_a),
    .loss_count (cnt_a)
  );

  reset_sequencer #(
    .SYNC_STAGES  (B_SYNC),
    .STABLE_CYCLES(B_STAB),
    .PIXEL_DELAY  (B_PIX)
  ) u_dut_b (
    .clk_core   (clk_core),
    .rst_n      (rst_n),
    .pll_locked (pll_b),
    .status_clr (status_clr),
    .core_rst_n (core_b),
    .pixel_rst_n(pix_b),
    .sys_ready  (rdy_b),
    .lock_lost  (lost_b),
    .loss_count (cnt_b)
  );

  always #5 clk_core = ~clk_core;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  // Model: lock counts as qualified after 'run' consecutive high samples.
  // Seen through the synchronizer delay, core is out of reset once the run
  // reaches STABLE+1, and pixel once it reaches STABLE+1+PIXEL_DELAY.
  int       run_m   [2];
  int       rh      [2][8];
  int       last_rst[2];
  bit       core_prv[2];
  bit       lost_m  [2];
  int       cnt_m   [2];
  int       s_m, t1_m, t2_m, eff_m, idx_m;
  bit       pll_m, core_e, pix_e, loss_m;
  logic [2:0] wi_m, ri_m;

  initial begin
    for (int i = 0; i < 2; i++) begin
      run_m[i]    = 0;
      last_rst[i] = 0;
      core_prv[i] = 1'b0;
      lost_m[i]   = 1'b0;
      cnt_m[i]    = 0;
      for (int j = 0; j < 8; j++) rh[i][j] = 0;
    end
  end

  always @(posedge clk_core) begin
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      s_m   = (i == 0) ? A_SYNC : B_SYNC;
      t1_m  = ((i == 0) ? A_STAB : B_STAB) + 1;
      t2_m  = t1_m + ((i == 0) ? A_PIX : B_PIX);
      pll_m = (i == 0) ? pll_a : pll_b;
      if (!rst_n) begin
        run_m[i]    = 0;
        last_rst[i] = cyc;
      end else begin
        run_m[i] = pll_m ? run_m[i] + 1 : 0;
      end
      wi_m = 3'(cyc);
      rh[i][wi_m] = run_m[i];
      idx_m = cyc - s_m;
      ri_m  = 3'(idx_m);
      eff_m = (idx_m <= last_rst[i]) ? 0 : rh[i][ri_m];
      core_e = (eff_m >= t1_m);
      pix_e  = (eff_m >= t2_m);
      loss_m = rst_n && core_prv[i] && !core_e;
      core_prv[i] = core_e;
      if (!rst_n)          lost_m[i] = 1'b0;
      else if (loss_m)     lost_m[i] = 1'b1;
      else if (status_clr) lost_m[i] = 1'b0;
      if (!rst_n)
        cnt_m[i] = 0;
      else if (loss_m && CNT_EN && cnt_m[i] < 255)
        cnt_m[i] = cnt_m[i] + 1;
      if (i == 0) begin
        chk("model core_rst_n A", int'(core_a), int'(core_e));
        chk("model pixel_rst_n A", int'(pix_a), int'(pix_e));
        chk("model sys_ready A", int'(rdy_a), int'(pix_e));
        chk("model lock_lost A", int'(lost_a), int'(lost_m[0]));
        chk("model loss_count A", int'(cnt_a), cnt_m[0]);
      end else begin
        chk("model core_rst_n B", int'(core_b), int'(core_e));
        chk("model pixel_rst_n B", int'(pix_b), int'(pix_e));
        chk("model sys_ready B", int'(rdy_b), int'(pix_e));
        chk("model lock_lost B", int'(lost_b), int'(lost_m[1]));
        chk("model loss_count B", int'(cnt_b), cnt_m[1]);
      end
    end
  end

  // Directed stimulus with hand-computed timing pins.
  initial begin
    rst_n      = 1'b0;
    pll_a      = 1'b0;
    pll_b      = 1'b0;
    status_clr = 1'b0;
    step(4);
    chk("reset core_rst_n", int'(core_a), 0);
    chk("reset pixel_rst_n", int'(pix_a), 0);
    chk("reset sys_ready", int'(rdy_a), 0);
    chk("reset lock_lost", int'(lost_a), 0);
    chk("reset loss_count", int'(cnt_a), 0);

    // Power-up: core at edge 1027, pixel/ready at edge 1043.
    rst_n = 1'b1;
    pll_a = 1'b1;
    step(1026);
    chk("core before 1027", int'(core_a), 0);
    step(1);
    chk("core at 1027", int'(core_a), 1);
    chk("pixel at 1027", int'(pix_a), 0);
    step(15);
    chk("pixel at 1042", int'(pix_a), 0);
    step(1);
    chk("pixel at 1043", int'(pix_a), 1);
    chk("ready at 1043", int'(rdy_a), 1);

    // Lock loss in RUN: outputs drop on the third edge after the drop.
    pll_a = 1'b0;
    step(2);
    chk("core still up before loss", int'(core_a), 1);
    step(1);
    chk("core after loss", int'(core_a), 0);
    chk("pixel after loss", int'(pix_a), 0);
    chk("ready after loss", int'(rdy_a), 0);
    chk("lock_lost after loss", int'(lost_a), 1);
    chk("loss_count after loss", int'(cnt_a), CNT_EN ? 1 : 0);

    // Re-lock repeats the full sequence.
    pll_a = 1'b1;
    step(1026);
    chk("relock core before 1027", int'(core_a), 0);
    step(1);
    chk("relock core at 1027", int'(core_a), 1);
    step(16);
    chk("relock pixel at 1043", int'(pix_a), 1);
    chk("lock_lost sticky", int'(lost_a), 1);

    // Clear alone, then a loss coinciding with clear, then clear alone again.
    status_clr = 1'b1;
    step(1);
    status_clr = 1'b0;
    chk("clear lock_lost", int'(lost_a), 0);
    pll_a = 1'b0;
    step(2);
    status_clr = 1'b1;
    step(1);
    status_clr = 1'b0;
    chk("loss wins over clear", int'(lost_a), 1);
    chk("core after loss 2", int'(core_a), 0);
    chk("loss_count after loss 2", int'(cnt_a), CNT_EN ? 2 : 0);
    step(4);
    status_clr = 1'b1;
    step(1);
    status_clr = 1'b0;
    chk("clear after coincident", int'(lost_a), 0);
    chk("count unchanged by clear", int'(cnt_a), CNT_EN ? 2 : 0);

    // Short glitch during qualification restarts from zero, no loss.
    pll_a = 1'b1;
    step(500);
    pll_a = 1'b0;
    step(3);
    chk("core during glitch", int'(core_a), 0);
    pll_a = 1'b1;
    step(1026);
    chk("glitch core before 1027", int'(core_a), 0);
    chk("glitch lock_lost", int'(lost_a), 0);
    step(1);
    chk("glitch core at 1027", int'(core_a), 1);
    chk("glitch lock_lost after", int'(lost_a), 0);

    // Reset pulse while in CORE_UP.
    step(3);
    chk("in core_up pixel", int'(pix_a), 0);
    rst_n = 1'b0;
    step(1);
    chk("mid reset core", int'(core_a), 0);
    chk("mid reset pixel", int'(pix_a), 0);
    chk("mid reset ready", int'(rdy_a), 0);
    chk("mid reset count", int'(cnt_a), 0);
    rst_n = 1'b1;
    step(1026);
    chk("post reset core before 1027", int'(core_a), 0);
    step(1);
    chk("post reset core at 1027", int'(core_a), 1);

    // Instance B: 300 loss events for saturation (core at 6, pixel at 7).
    for (int k = 1; k <= 300; k++) begin
      pll_b = 1'b1;
      step(5);
      if (k == 1) chk("B core before 6", int'(core_b), 0);
      step(1);
      if (k == 1) chk("B core at 6", int'(core_b), 1);
      step(1);
      if (k == 1) chk("B pixel at 7", int'(pix_b), 1);
      pll_b = 1'b0;
      step(4);
      if (k == 1 || k == 255 || k == 256 || k == 300) begin
        chk("B loss_count", int'(cnt_b), CNT_EN ? ((k > 255) ? 255 : k) : 0);
        chk("B lock_lost", int'(lost_b), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, which sets the number of synchronizer flops on pll_locked (legal range 2..4).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1024, which sets how many consecutive cycles of synchronized lock are required before core reset release (legal range 2..65535).
REQ-003 The block SHALL have parameter PIXEL_DELAY, default 16, which sets the number of cycles between core reset release and pixel reset release (legal range 1..255).
REQ-004 The block SHALL have port clk_core, input, width 1: the 100 MHz unified core clock and the only clock of the block.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port pll_locked, input, width 1: raw PLL lock indicator, asynchronous to clk_core.
REQ-007 The block SHALL have port status_clr, input, width 1: single-cycle pulse that clears lock_lost.
REQ-008 The block SHALL have port core_rst_n, output, width 1: active-low reset for core/SRAM logic.
REQ-009 The block SHALL have port pixel_rst_n, output, width 1: active-low reset for pixel/TMDS logic.
REQ-010 The block SHALL have port sys_ready, output, width 1: high only in state RUN.
REQ-011 The block SHALL have port lock_lost, output, width 1: sticky flag set on loss of lock after core release.
REQ-012 The block SHALL have port loss_count, output, width 8: count of lock-loss events.

Function
REQ-013 pll_locked SHALL pass through SYNC_STAGES flops; downstream logic SHALL use only the last flop (lock_s).
REQ-014 The state machine SHALL have states WAIT_LOCK, STABLE, CORE_UP and RUN; all outputs SHALL be registered or decoded from registered state only.
REQ-015 WAIT_LOCK: core_rst_n=0, pixel_rst_n=0; lock_s=1 -> STABLE with the stable counter cleared.
REQ-016 STABLE: the counter SHALL increment each cycle lock_s=1; lock_s=0 -> WAIT_LOCK with no loss event; counter==STABLE_CYCLES-1 -> CORE_UP.
REQ-017 CORE_UP: core_rst_n=1, pixel_rst_n=0; the delay counter SHALL run for PIXEL_DELAY cycles, then -> RUN.
REQ-018 RUN: core_rst_n=1, pixel_rst_n=1, sys_ready=1.
REQ-019 With default parameters, core_rst_n SHALL rise exactly SYNC_STAGES+STABLE_CYCLES+1 rising edges after the first edge that samples pll_locked high (1027 cycles).
REQ-020 pixel_rst_n SHALL rise exactly PIXEL_DELAY cycles after core_rst_n rises.
REQ-021 lock_s=0 in CORE_UP or RUN SHALL deassert core_rst_n, pixel_rst_n and sys_ready on the next edge, set lock_lost, record one loss event, and -> WAIT_LOCK.
REQ-022 If status_clr and a loss event occur in the same cycle, lock_lost SHALL remain set.
REQ-023 A pll_locked glitch shorter than STABLE_CYCLES before core release SHALL restart qualification from zero and SHALL NOT set lock_lost.
REQ-024 Counters SHALL be sized to their parameter; the stable counter SHALL NOT wrap.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force: state=WAIT_LOCK, all synchronizer flops=0, all counters=0, core_rst_n=0, pixel_rst_n=0, sys_ready=0, lock_lost=0, loss_count=0.
REQ-026 rst_n asserted mid-sequence, in any state, SHALL apply REQ-025 on that edge and restart full qualification after release.

Configuration
REQ-027 The macro RESET_SEQ_LOSS_CNT_EN SHALL control the loss counter.
REQ-028 With RESET_SEQ_LOSS_CNT_EN defined, loss_count SHALL increment by 1 per loss event and saturate at 255; status_clr SHALL NOT clear it.
REQ-029 Without RESET_SEQ_LOSS_CNT_EN, loss_count SHALL be constant 0 and no counter flops SHALL be generated.

Verification
REQ-030 rst_n low 4 cycles, then pll_locked held high -> core_rst_n rises at edge 1027, pixel_rst_n at 1043, and sys_ready=1 from 1043.
REQ-031 pll_locked high 500 cycles, low 3 cycles, then high -> core_rst_n stays 0 through the glitch, releases 1027 edges after re-lock, and lock_lost=0.
REQ-032 In RUN, drop pll_locked -> core_rst_n=0, pixel_rst_n=0, lock_lost=1 and loss_count=1 within SYNC_STAGES+1 edges; after re-lock the full 1027/16 sequence repeats.
REQ-033 Loss event and status_clr in the same cycle -> lock_lost=1; status_clr alone later -> lock_lost=0 and loss_count unchanged.
REQ-034 300 loss events with the macro defined -> loss_count=255; with the macro undefined -> loss_count=0.
REQ-035 rst_n pulsed low in CORE_UP -> all outputs 0 on that edge, and core_rst_n re-rises 1027 edges after rst_n returns high with pll_locked high.
